// File: rtl/cache_tag_sequencer.sv
// Tag/valid store and request sequencer for the pseudo-LRU way-selection unit.
// Optional macro CACHE_TAG_FLUSH_EN adds a set-by-set valid flush engine.
module cache_tag_sequencer #(
    parameter int NUM_SETS        = 64,
    parameter int NUM_WAYS        = 4,
    parameter int TAG_WIDTH       = 20,
    parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
    // Held at 1 bit minimum so a direct-mapped build still has a legal way port
    parameter int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       lookup_valid,
    input  logic [SET_INDEX_WIDTH-1:0] lookup_set,
    input  logic [TAG_WIDTH-1:0]       lookup_tag,
    output logic                       lookup_ready,
    output logic                       lookup_done,
    output logic                       lookup_hit,
    output logic [WAY_INDEX_WIDTH-1:0] lookup_way,
    input  logic                       fill_valid,
    input  logic [SET_INDEX_WIDTH-1:0] fill_set,
    input  logic [TAG_WIDTH-1:0]       fill_tag,
    output logic                       fill_ready,
    output logic                       fill_done,
    output logic [WAY_INDEX_WIDTH-1:0] fill_way_out,
    output logic                       lru_fill_en,
    output logic [SET_INDEX_WIDTH-1:0] lru_fill_set,
    input  logic [WAY_INDEX_WIDTH-1:0] lru_fill_way,
    output logic                       lru_access_en,
    output logic [SET_INDEX_WIDTH-1:0] lru_access_set,
    output logic                       lru_access_update_en,
    output logic [WAY_INDEX_WIDTH-1:0] lru_access_update_way
`ifdef CACHE_TAG_FLUSH_EN
    ,
    input  logic                       flush_req,
    output logic                       flush_busy,
    output logic                       flush_done
`endif
);

    localparam int S = SET_INDEX_WIDTH;
    localparam int W = WAY_INDEX_WIDTH;

    logic [NUM_WAYS-1:0]  r_valid [NUM_SETS];
    logic [TAG_WIDTH-1:0] r_tags  [NUM_SETS][NUM_WAYS];

    logic                 r_fill_p1;
    logic                 r_lk_p1;
    logic [S-1:0]         r_set_p1;
    logic [TAG_WIDTH-1:0] r_tag_p1;

    logic                 w_flush_active;
    logic                 w_clr_en;
    logic [S-1:0]         w_clr_set;
    logic                 w_fill_acc;
    logic                 w_lk_acc;
    logic [NUM_WAYS-1:0]  w_match;
    logic [W-1:0]         w_enc;

`ifdef CACHE_TAG_FLUSH_EN
    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [S-1:0] r_flush_cnt;
    logic [S-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_flush_cnt;
        flush_busy  = 1'b0;
        flush_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Entry waits for a cycle with no acceptance so stage 1 is empty during the sweep
                if (flush_req && !w_fill_acc && !w_lk_acc)
                    w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush_busy = 1'b1;
                if (r_flush_cnt == S'(NUM_SETS - 1)) begin
                    flush_done  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_flush_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_flush_active = (r_state == ST_FLUSH);
    assign w_clr_en       = w_flush_active;
    assign w_clr_set      = r_flush_cnt;
`else
    assign w_flush_active = 1'b0;
    assign w_clr_en       = 1'b0;
    assign w_clr_set      = '0;
`endif

    // Stage 0: acceptance, fill has priority, LRU requests issued same cycle
    assign fill_ready     = !w_flush_active;
    assign lookup_ready   = !fill_valid && !w_flush_active;
    assign w_fill_acc     = fill_valid && fill_ready;
    assign w_lk_acc       = lookup_valid && lookup_ready;
    assign lru_fill_en    = w_fill_acc;
    assign lru_fill_set   = fill_set;
    assign lru_access_en  = w_lk_acc;
    assign lru_access_set = lookup_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fill_p1 <= 1'b0;
            r_lk_p1   <= 1'b0;
        end else begin
            r_fill_p1 <= w_fill_acc;
            r_lk_p1   <= w_lk_acc;
        end
    end

    always_ff @(posedge clk) begin
        r_set_p1 <= w_fill_acc ? fill_set : lookup_set;
        r_tag_p1 <= w_fill_acc ? fill_tag : lookup_tag;
    end

    // Stage 1: compare registered tag against the set, or write the fill into the LRU-chosen way
    always_comb begin
        w_match = '0;
        w_enc   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            w_match[w] = r_valid[r_set_p1][w] && (r_tags[r_set_p1][w] == r_tag_p1);
            if (w_match[w])
                w_enc = w_enc | W'(w);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_SETS; s++)
                r_valid[s] <= '0;
        end else begin
            if (w_clr_en)
                r_valid[w_clr_set] <= '0;
            if (r_fill_p1)
                r_valid[r_set_p1][lru_fill_way] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_fill_p1)
            r_tags[r_set_p1][lru_fill_way] <= r_tag_p1;
    end

    assign lookup_done           = r_lk_p1;
    assign lookup_hit            = r_lk_p1 && (|w_match);
    assign lookup_way            = lookup_hit ? w_enc : '0;
    assign fill_done             = r_fill_p1;
    assign fill_way_out          = r_fill_p1 ? lru_fill_way : '0;
    assign lru_access_update_en  = lookup_hit;
    assign lru_access_update_way = lookup_way;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n && r_lk_p1)
            assert ($onehot0(w_match)) else $error("lookup matched more than one way");
        if (reset_n && r_fill_p1)
            assert (w_match == '0) else $error("fill tag already present in its set");
    end
`endif

endmodule

// File: tb/tb_cache_tag_sequencer.sv
// Bench for cache_tag_sequencer: directed vector table, reset/flush sequences and a
// randomized run against a set/way array model; the bench plays the LRU unit.
module tb_cache_tag_sequencer;

    localparam int NS = 64;
    localparam int NW = 4;
    localparam int TW = 20;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          lookup_valid = 1'b0;
    logic [5:0]    lookup_set = '0;
    logic [TW-1:0] lookup_tag = '0;
    logic          lookup_ready, lookup_done, lookup_hit;
    logic [1:0]    lookup_way;
    logic          fill_valid = 1'b0;
    logic [5:0]    fill_set = '0;
    logic [TW-1:0] fill_tag = '0;
    logic          fill_ready, fill_done;
    logic [1:0]    fill_way_out;
    logic          lru_fill_en;
    logic [5:0]    lru_fill_set;
    logic [1:0]    lru_fill_way = '0;
    logic          lru_access_en;
    logic [5:0]    lru_access_set;
    logic          lru_access_update_en;
    logic [1:0]    lru_access_update_way;
`ifdef CACHE_TAG_FLUSH_EN
    logic          flush_req = 1'b0;
    logic          flush_busy, flush_done;
`endif

    cache_tag_sequencer #(.NUM_SETS(NS), .NUM_WAYS(NW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset_n(reset_n),
        .lookup_valid(lookup_valid), .lookup_set(lookup_set), .lookup_tag(lookup_tag),
        .lookup_ready(lookup_ready), .lookup_done(lookup_done), .lookup_hit(lookup_hit),
        .lookup_way(lookup_way),
        .fill_valid(fill_valid), .fill_set(fill_set), .fill_tag(fill_tag),
        .fill_ready(fill_ready), .fill_done(fill_done), .fill_way_out(fill_way_out),
        .lru_fill_en(lru_fill_en), .lru_fill_set(lru_fill_set), .lru_fill_way(lru_fill_way),
        .lru_access_en(lru_access_en), .lru_access_set(lru_access_set),
        .lru_access_update_en(lru_access_update_en),
        .lru_access_update_way(lru_access_update_way)
`ifdef CACHE_TAG_FLUSH_EN
        ,
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then stop at the falling edge to sample
    task automatic drive(input bit fv, input bit [5:0] fs, input bit [TW-1:0] ft,
                         input bit lv, input bit [5:0] ls, input bit [TW-1:0] lt,
                         input bit [1:0] lw);
        fill_valid   = fv;
        fill_set     = fs;
        fill_tag     = ft;
        lookup_valid = lv;
        lookup_set   = ls;
        lookup_tag   = lt;
        lru_fill_way = lw;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Model of the cache contents: one tag and valid flag per (set, way)
    bit [TW-1:0] m_tag [NS][NW];
    bit          m_vld [NS][NW];

    task automatic m_clear();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++)
                m_vld[s][w] = 1'b0;
    endtask

    task automatic m_lookup(input int s, input bit [TW-1:0] t, output bit hit, output int way);
        hit = 1'b0;
        way = 0;
        for (int w = 0; w < NW; w++)
            if (m_vld[s][w] && m_tag[s][w] == t) begin
                hit = 1'b1;
                way = w;
            end
    endtask

    typedef struct packed {
        bit          fv;
        bit [5:0]    fs;
        bit [TW-1:0] ft;
        bit          lv;
        bit [5:0]    ls;
        bit [TW-1:0] lt;
        bit [1:0]    lw;
        bit          e_fdone;
        bit [1:0]    e_fway;
        bit          e_ldone;
        bit          e_hit;
        bit [1:0]    e_lway;
    } vec_t;

    vec_t vt [16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          p_fill, p_lk, hit, fv, lv;
        int          p_set, way, fs, ls, k;
        bit [TW-1:0] p_tag, ft, lt;
        bit [1:0]    lw;
        int          iss_set[$];
        bit [TW-1:0] iss_tag[$];

        //            fv    fs     ft         lv    ls     lt         lw    fdone fway  ldone hit   lway
        vt[0]  = '{1'b0, 6'd0, 20'h00000, 1'b1, 6'd3, 20'h12345, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0};
        vt[1]  = '{1'b1, 6'd3, 20'h12345, 1'b0, 6'd0, 20'h00000, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0};
        vt[2]  = '{1'b0, 6'd0, 20'h00000, 1'b1, 6'd3, 20'h12345, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0};
        vt[3]  = '{1'b1, 6'd7, 20'hAAAAA, 1'b1, 6'd3, 20'h12345, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2};
        vt[4]  = '{1'b0, 6'd0, 20'h00000, 1'b1, 6'd3, 20'h12345, 2'd1, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0};
        vt[5]  = '{1'b1, 6'd5, 20'h00050, 1'b0, 6'd0, 20'h00000, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2};
        vt[6]  = '{1'b1, 6'd5, 20'h00051, 1'b0, 6'd0, 20'h00000, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0};
        vt[7]  = '{1'b1, 6'd5, 20'h00052, 1'b0, 6'd0, 20'h00000, 2'd1, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0};
        vt[8]  = '{1'b1, 6'd5, 20'h00053, 1'b0, 6'd0, 20'h00000, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0};
        vt[9]  = '{1'b0, 6'd0, 20'h00000, 1'b1, 6'd5, 20'h00050, 2'd3, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0};
        vt[10] = '{1'b0, 6'd0, 20'h00000, 1'b1, 6'd5, 20'h00051, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0};
        vt[11] = '{1'b0, 6'd0, 20'h00000, 1'b1, 6'd5, 20'h00052, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1};
        vt[12] = '{1'b0, 6'd0, 20'h00000, 1'b1, 6'd5, 20'h00053, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2};
        vt[13] = '{1'b0, 6'd0, 20'h00000, 1'b1, 6'd7, 20'hAAAAA, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3};
        vt[14] = '{1'b0, 6'd0, 20'h00000, 1'b1, 6'd5, 20'h99999, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1};
        vt[15] = '{1'b0, 6'd0, 20'h00000, 1'b0, 6'd0, 20'h00000, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0};

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.lookup_done", 32'(lookup_done), 32'd0);
        chk("rst.fill_done", 32'(fill_done), 32'd0);
        chk("rst.lookup_hit", 32'(lookup_hit), 32'd0);
        chk("rst.lookup_way", 32'(lookup_way), 32'd0);
        chk("rst.fill_way_out", 32'(fill_way_out), 32'd0);
        chk("rst.update_en", 32'(lru_access_update_en), 32'd0);
        reset_n = 1'b1;
        adv();

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].fv, vt[i].fs, vt[i].ft, vt[i].lv, vt[i].ls, vt[i].lt, vt[i].lw);
            chk($sformatf("v%0d.lookup_ready", i), 32'(lookup_ready), 32'(!vt[i].fv));
            chk($sformatf("v%0d.fill_ready", i), 32'(fill_ready), 32'd1);
            chk($sformatf("v%0d.lru_fill_en", i), 32'(lru_fill_en), 32'(vt[i].fv));
            if (vt[i].fv)
                chk($sformatf("v%0d.lru_fill_set", i), 32'(lru_fill_set), 32'(vt[i].fs));
            chk($sformatf("v%0d.lru_access_en", i), 32'(lru_access_en), 32'(vt[i].lv && !vt[i].fv));
            if (vt[i].lv && !vt[i].fv)
                chk($sformatf("v%0d.lru_access_set", i), 32'(lru_access_set), 32'(vt[i].ls));
            chk($sformatf("v%0d.fill_done", i), 32'(fill_done), 32'(vt[i].e_fdone));
            if (vt[i].e_fdone)
                chk($sformatf("v%0d.fill_way_out", i), 32'(fill_way_out), 32'(vt[i].e_fway));
            chk($sformatf("v%0d.lookup_done", i), 32'(lookup_done), 32'(vt[i].e_ldone));
            chk($sformatf("v%0d.lookup_hit", i), 32'(lookup_hit), 32'(vt[i].e_hit));
            chk($sformatf("v%0d.lookup_way", i), 32'(lookup_way), 32'(vt[i].e_lway));
            chk($sformatf("v%0d.update_en", i), 32'(lru_access_update_en), 32'(vt[i].e_hit));
            chk($sformatf("v%0d.update_way", i), 32'(lru_access_update_way), 32'(vt[i].e_lway));
            adv();
        end

        // Reset while a fill sits in stage 1: no done pulse, and the tag never lands
        drive(1'b1, 6'd9, 20'hBEEF0, 1'b0, 6'd0, 20'h0, 2'd0);
        chk("rstmid.lru_fill_en", 32'(lru_fill_en), 32'd1);
        @(posedge clk);
        #1;
        fill_valid   = 1'b0;
        lru_fill_way = 2'd1;
        reset_n      = 1'b0;
        #1;
        chk("rstmid.fill_done", 32'(fill_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        adv();
        drive(1'b0, 6'd0, 20'h0, 1'b1, 6'd9, 20'hBEEF0, 2'd0);
        adv();
        drive(1'b0, 6'd0, 20'h0, 1'b1, 6'd3, 20'h12345, 2'd0);
        chk("rstmid.lookup_done", 32'(lookup_done), 32'd1);
        chk("rstmid.dropped_fill_hit", 32'(lookup_hit), 32'd0);
        adv();
        drive(1'b0, 6'd0, 20'h0, 1'b0, 6'd0, 20'h0, 2'd0);
        chk("rstmid.cleared_hit", 32'(lookup_hit), 32'd0);
        adv();

        // Randomized traffic against the model; every fill uses a never-before-seen tag
        m_clear();
        p_fill = 1'b0;
        p_lk   = 1'b0;
        p_set  = 0;
        p_tag  = '0;
        k      = 0;
        for (int c = 0; c < 600; c++) begin
            fv = ($urandom_range(0, 99) < 35);
            lv = ($urandom_range(0, 99) < 65);
            fs = $urandom_range(0, 7);
            ft = 20'h40000 + TW'(k);
            if (iss_set.size() > 0 && $urandom_range(0, 3) != 0) begin
                int idx;
                idx = $urandom_range(0, iss_set.size() - 1);
                ls  = iss_set[idx];
                lt  = iss_tag[idx];
            end else begin
                ls = $urandom_range(0, 7);
                lt = TW'($urandom_range(0, 20'h3FFFF));
            end
            lw = 2'($urandom_range(0, 3));
            drive(fv, 6'(fs), ft, lv, 6'(ls), lt, lw);

            chk("rnd.lookup_ready", 32'(lookup_ready), 32'(!fv));
            chk("rnd.lru_fill_en", 32'(lru_fill_en), 32'(fv));
            chk("rnd.lru_access_en", 32'(lru_access_en), 32'(lv && !fv));
            if (fv)
                chk("rnd.lru_fill_set", 32'(lru_fill_set), 32'(fs));
            else if (lv)
                chk("rnd.lru_access_set", 32'(lru_access_set), 32'(ls));

            chk("rnd.fill_done", 32'(fill_done), 32'(p_fill));
            if (p_fill) begin
                chk("rnd.fill_way_out", 32'(fill_way_out), 32'(lw));
                m_tag[p_set][lw] = p_tag;
                m_vld[p_set][lw] = 1'b1;
            end
            chk("rnd.lookup_done", 32'(lookup_done), 32'(p_lk));
            if (p_lk) begin
                m_lookup(p_set, p_tag, hit, way);
                chk("rnd.lookup_hit", 32'(lookup_hit), 32'(hit));
                chk("rnd.lookup_way", 32'(lookup_way), hit ? 32'(way) : 32'd0);
                chk("rnd.update_en", 32'(lru_access_update_en), 32'(hit));
                if (hit)
                    chk("rnd.update_way", 32'(lru_access_update_way), 32'(way));
            end else begin
                chk("rnd.update_en_idle", 32'(lru_access_update_en), 32'd0);
            end

            p_fill = fv;
            p_lk   = lv && !fv;
            if (fv) begin
                p_set = fs;
                p_tag = ft;
                iss_set.push_back(fs);
                iss_tag.push_back(ft);
                k++;
            end else if (lv) begin
                p_set = ls;
                p_tag = lt;
            end
            adv();
        end
        drive(1'b0, 6'd0, 20'h0, 1'b0, 6'd0, 20'h0, 2'd0);
        adv();

`ifdef CACHE_TAG_FLUSH_EN
        // Flush: fill three sets, sweep all sets, then every earlier fill must miss
        drive(1'b1, 6'd10, 20'h70010, 1'b0, 6'd0, 20'h0, 2'd0);
        adv();
        drive(1'b1, 6'd11, 20'h70011, 1'b0, 6'd0, 20'h0, 2'd1);
        adv();
        drive(1'b1, 6'd12, 20'h70012, 1'b0, 6'd0, 20'h0, 2'd2);
        adv();
        drive(1'b0, 6'd0, 20'h0, 1'b1, 6'd12, 20'h70012, 2'd3);
        adv();
        drive(1'b0, 6'd0, 20'h0, 1'b0, 6'd0, 20'h0, 2'd0);
        chk("flush.prefill_hit", 32'(lookup_hit), 32'd1);
        flush_req = 1'b1;
        #1;
        chk("flush.busy_before", 32'(flush_busy), 32'd0);
        adv();
        flush_req = 1'b0;
        drive(1'b0, 6'd0, 20'h0, 1'b1, 6'd10, 20'h70010, 2'd0);
        for (int i = 0; i < NS; i++) begin
            chk($sformatf("flush.busy%0d", i), 32'(flush_busy), 32'd1);
            chk($sformatf("flush.lookup_ready%0d", i), 32'(lookup_ready), 32'd0);
            chk($sformatf("flush.fill_ready%0d", i), 32'(fill_ready), 32'd0);
            chk($sformatf("flush.access_en%0d", i), 32'(lru_access_en), 32'd0);
            chk($sformatf("flush.done%0d", i), 32'(flush_done), 32'(i == NS - 1));
            adv();
            @(negedge clk);
        end
        chk("flush.busy_after", 32'(flush_busy), 32'd0);
        chk("flush.ready_after", 32'(lookup_ready), 32'd1);
        adv();
        drive(1'b0, 6'd0, 20'h0, 1'b1, 6'd11, 20'h70011, 2'd0);
        chk("flush.set10_done", 32'(lookup_done), 32'd1);
        chk("flush.set10_hit", 32'(lookup_hit), 32'd0);
        adv();
        drive(1'b0, 6'd0, 20'h0, 1'b1, 6'd12, 20'h70012, 2'd0);
        chk("flush.set11_hit", 32'(lookup_hit), 32'd0);
        adv();
        drive(1'b0, 6'd0, 20'h0, 1'b0, 6'd0, 20'h0, 2'd0);
        chk("flush.set12_hit", 32'(lookup_hit), 32'd0);
        adv();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
